twiddle_rotator: RTL and testbench
==================================

// Module: twiddle_rotator
// PURPOSE
//  Streaming twiddle multiplier between the radix-4 butterfly stages of the 16-point FFT.
//  Drives the twiddle lookup select, consumes the returned twiddle (stage-1 outputs only).
//  Multiplies each sample by W16^e, where e = p*q, p = idx[3:2], q = idx[1:0] of its frame index.
//  The twiddle table holds W16^0..W16^7; exponents 8..9 are formed by negating W16^(e-8).
// PARAMETERS
//  DATA_WIDTH  12  width of each real/imag sample and twiddle component (two's complement)
//  N           3   twiddle select width; table depth 2**N = W16^0..W16^7
// PORTS
//  clk       in   1           clock, all logic on rising edge
//  rst       in   1           synchronous reset, active-high
//  in_valid  in   1           input sample valid
//  in_ready  out  1           block can accept a sample this cycle
//  in_sof    in   1           start of frame: accepted sample is index 0
//  in_r      in   DATA_WIDTH  input real part
//  in_i      in   DATA_WIDTH  input imaginary part
//  sel       out  N           twiddle select to the lookup (combinational)
//  W_r       in   DATA_WIDTH  twiddle real, Q1.(DATA_WIDTH-2); 1.0 = 2**(DATA_WIDTH-2)
//  W_i       in   DATA_WIDTH  twiddle imaginary, same format
//  out_valid out  1           output sample valid
//  out_ready in   1           downstream accepts output this cycle
//  out_r     out  DATA_WIDTH  rotated real part
//  out_i     out  DATA_WIDTH  rotated imaginary part
//  out_idx   out  4           frame index of the output sample
//  out_last  out  1           high when out_idx == 15
// BEHAVIOUR
//  Reset: frame counter = 0; all stage valids, out_valid, out_r, out_i, out_idx, out_last = 0.
//  Accept: in_valid && in_ready. idx = in_sof ? 0 : cnt. On accept, cnt <= idx + 1 (mod 16).
//    15 -> 0 wraps silently. in_sof mid-frame resyncs; no error flag is raised.
//  e = idx[3:2]*idx[1:0] (0..9). sel = e[N-1:0] (e mod 8). neg = (e >= 8).
//    sel is driven every cycle from the would-be idx, even when no accept occurs.
//  W_r/W_i are sampled in the accept cycle, together with in_r, in_i, idx and neg.
//  Pipeline: S1 capture -> S2 four signed products -> S3 sum/round/saturate/negate -> output reg.
//    Latency = 3 cycles from accept to out_valid when unstalled. Throughput = 1 sample/cycle.
//  Stall: adv = !out_valid || out_ready. All stages advance only when adv. in_ready = adv.
//    Data and valids hold while !adv. A bubble (valid = 0) propagates like data.
//  Arithmetic: pr = in_r*W_r - in_i*W_i; pi = in_r*W_i + in_i*W_r.
//    Accumulate at full width, 2*DATA_WIDTH+1 bits.
//    Round half up: add 2**(DATA_WIDTH-3), then arithmetic shift right by DATA_WIDTH-2.
//    Saturate to DATA_WIDTH, range [-2**(DW-1), 2**(DW-1)-1].
//    If neg, negate the saturated result, then saturate again (-min -> max).
//  out_idx and out_last travel with their sample. Output registers update only when adv.
//  Reset mid-frame clears everything in flight. The first accept after reset is index 0,
//    regardless of in_sof.
// TESTING
//  T1 identity: reset, in_sof, 16 samples (0x123,0x0AB). Idx 0-4, 8, 12 return the input exactly.
//     Output idx 0 appears 3 cycles after its accept; out_last is high only on idx 15.
//  T2 rotation: idx 5 (sel=1, W=0x3B2,0xE78), in (0x400,0x000) -> out (0x3B2,0xE78).
//  T3 negate: idx 15 (e=9, sel=1, neg), in (0x400,0x000) -> out (0xC4E,0x188).
//     Idx 10 (sel=4, W=0x000,0xC00), in (0x100,0x080) -> out (0x080,0xF00).
//  T4 saturation: idx 10, in (0x800,0x000) -> out (0x000,0x7FF).
//     Idx 14 (e=6, neg=0), in (0x7FF,0x7FF) -> no wrap; each part within range.
//  T5 backpressure: out_ready low for 6 cycles with in_valid high.
//     in_ready drops once the pipe fills. No sample is lost or duplicated.
//     Order and idx are preserved after release.
//  T6 resync/reset: in_sof at cnt=7 -> that sample has out_idx 0, and sel follows the new idx.
//     rst asserted mid-frame with the pipe full -> out_valid is 0 on the next cycle.
//     The next accept has idx 0.

Source files
------------

// File: rtl/twiddle_rotator.sv
// Streaming complex multiply by W16^(p*q) for the inter-stage twiddles of a 16-point radix-4 FFT.
// Three-stage pipe (capture, products, round/saturate/negate) under a single global stall.
module twiddle_rotator #(
   parameter int DATA_WIDTH = 12,
   parameter int N          = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_sof,
   input  logic [DATA_WIDTH-1:0] in_r,
   input  logic [DATA_WIDTH-1:0] in_i,
   output logic [N-1:0]          sel,
   input  logic [DATA_WIDTH-1:0] W_r,
   input  logic [DATA_WIDTH-1:0] W_i,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_r,
   output logic [DATA_WIDTH-1:0] out_i,
   output logic [3:0]            out_idx,
   output logic                  out_last
);
   localparam int DW = DATA_WIDTH;
   localparam int PW = 2 * DW;
   localparam int AW = 2 * DW + 1;
   localparam int SH = DW - 2;
   localparam int RW = AW - SH;

   localparam logic signed [RW-1:0] SAT_MAX = RW'((1 << (DW - 1)) - 1);
   localparam logic signed [RW-1:0] SAT_MIN = RW'(-(1 << (DW - 1)));
   localparam logic signed [DW-1:0] D_MAX   = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] D_MIN   = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [AW-1:0] ROUND   = AW'(1 << (DW - 3));

   logic                 w_adv;
   logic                 w_accept;
   logic [3:0]           w_idx;
   logic [3:0]           w_e;
   logic                 w_neg;
   logic [3:0]           r_cnt;

   logic                 r_s1_valid;
   logic signed [DW-1:0] r_s1_r;
   logic signed [DW-1:0] r_s1_i;
   logic signed [DW-1:0] r_s1_wr;
   logic signed [DW-1:0] r_s1_wi;
   logic [3:0]           r_s1_idx;
   logic                 r_s1_neg;

   logic signed [PW-1:0] w_pa  [2];
   logic signed [PW-1:0] w_pb  [2];
   logic                 r_s2_valid;
   logic signed [PW-1:0] r_s2_pa [2];
   logic signed [PW-1:0] r_s2_pb [2];
   logic [3:0]           r_s2_idx;
   logic                 r_s2_neg;

   logic signed [DW-1:0] w_fin [2];
   logic                 r_out_valid;
   logic [DW-1:0]        r_out_r;
   logic [DW-1:0]        r_out_i;
   logic [3:0]           r_out_idx;
   logic                 r_out_last;

   // One advance signal freezes every stage together, so a held output also holds the front end.
   assign w_adv    = !r_out_valid || out_ready;
   assign w_accept = in_valid && w_adv;
   assign in_ready = w_adv;

   assign w_idx = in_sof ? 4'd0 : r_cnt;
   assign w_e   = {2'b00, w_idx[3:2]} * {2'b00, w_idx[1:0]};
   assign sel   = w_e[N-1:0];
   assign w_neg = (32'(w_e) >= (1 << N));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (w_accept) begin
            r_cnt <= w_idx + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_s1_r   <= in_r;
         r_s1_i   <= in_i;
         r_s1_wr  <= W_r;
         r_s1_wi  <= W_i;
         r_s1_idx <= w_idx;
         r_s1_neg <= w_neg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_part
         // Part 0 is real (r*Wr - i*Wi), part 1 is imaginary (r*Wi + i*Wr).
         logic signed [DW-1:0] w_wa;
         logic signed [DW-1:0] w_wb;
         logic signed [AW-1:0] w_acc;
         logic signed [AW-1:0] w_rnd;
         logic signed [RW-1:0] w_shr;
         logic signed [DW-1:0] w_sat;

         assign w_wa     = (gi == 0) ? r_s1_wr : r_s1_wi;
         assign w_wb     = (gi == 0) ? r_s1_wi : r_s1_wr;
         assign w_pa[gi] = PW'(r_s1_r) * PW'(w_wa);
         assign w_pb[gi] = PW'(r_s1_i) * PW'(w_wb);

         if (gi == 0) begin : g_sub
            assign w_acc = AW'(r_s2_pa[gi]) - AW'(r_s2_pb[gi]);
         end else begin : g_add
            assign w_acc = AW'(r_s2_pa[gi]) + AW'(r_s2_pb[gi]);
         end

         assign w_rnd = w_acc + ROUND;
         assign w_shr = w_rnd[AW-1:SH];

         always_comb begin
            w_sat = w_shr[DW-1:0];
            if (w_shr > SAT_MAX) begin
               w_sat = D_MAX;
            end else if (w_shr < SAT_MIN) begin
               w_sat = D_MIN;
            end
         end

         // Negating the most negative value cannot be represented, so it clamps to the maximum.
         assign w_fin[gi] = !r_s2_neg       ? w_sat :
                            (w_sat == D_MIN) ? D_MAX : -w_sat;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_adv) begin
         for (int k = 0; k < 2; k++) begin
            r_s2_pa[k] <= w_pa[k];
            r_s2_pb[k] <= w_pb[k];
         end
         r_s2_idx <= r_s1_idx;
         r_s2_neg <= r_s1_neg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_i     <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
      end else if (w_adv) begin
         r_s2_valid  <= r_s1_valid;
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_out_r    <= w_fin[0];
            r_out_i    <= w_fin[1];
            r_out_idx  <= r_s2_idx;
            r_out_last <= (r_s2_idx == 4'hF);
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_r     = r_out_r;
   assign out_i     = r_out_i;
   assign out_idx   = r_out_idx;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_twiddle_rotator.sv
// Bench for twiddle_rotator: emulates the W16 lookup and compares every output against
// an integer model of the rotation, rounding, saturation and negation rules.
module tb_twiddle_rotator;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sof;
   logic [11:0] in_r, in_i, W_r, W_i;
   logic [2:0]  sel;
   logic        out_valid, out_ready, out_last;
   logic [11:0] out_r, out_i;
   logic [3:0]  out_idx;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;
   int m_cnt   = 0;

   typedef struct {
      logic [11:0] r;
      logic [11:0] i;
      int          idx;
      logic        last;
      int          cyc;
   } smp_t;

   smp_t exp_q[$];
   smp_t obs_q[$];

   twiddle_rotator #(.DATA_WIDTH(12), .N(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_r(in_r), .in_i(in_i), .sel(sel), .W_r(W_r), .W_i(W_i),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_i(out_i), .out_idx(out_idx), .out_last(out_last)
   );

   always #5 clk = ~clk;

   // W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), scaled by 1024
   function automatic int tw_r(input int k);
      case (k)
         0: return 1024;  1: return 946;   2: return 724;   3: return 392;
         4: return 0;     5: return -392;  6: return -724;  default: return -946;
      endcase
   endfunction

   function automatic int tw_i(input int k);
      case (k)
         0: return 0;     1: return -392;  2: return -724;  3: return -946;
         4: return -1024; 5: return -946;  6: return -724;  default: return -392;
      endcase
   endfunction

   assign W_r = 12'(tw_r(int'(sel)));
   assign W_i = 12'(tw_i(int'(sel)));

   function automatic int sat12(input int v);
      if (v > 2047) return 2047;
      if (v < -2048) return -2048;
      return v;
   endfunction

   function automatic void model(input int idx, input logic [11:0] xr, input logic [11:0] xi,
                                 output logic [11:0] er, output logic [11:0] ei);
      int e, k, wr, wi, ar, ai, pr, pi;
      e  = (idx / 4) * (idx % 4);
      k  = e % 8;
      wr = tw_r(k);
      wi = tw_i(k);
      ar = int'($signed(xr));
      ai = int'($signed(xi));
      pr = sat12((ar * wr - ai * wi + 512) >>> 10);
      pi = sat12((ar * wi + ai * wr + 512) >>> 10);
      if (e >= 8) begin
         pr = sat12(-pr);
         pi = sat12(-pi);
      end
      er = 12'(pr);
      ei = 12'(pi);
   endfunction

   // Drives one cycle from a negedge; records outputs consumed and samples accepted this cycle.
   task automatic step(input bit v, input bit sof, input logic [11:0] xr, input logic [11:0] xi,
                       input bit ordy, output bit acc);
      smp_t s;
      logic [11:0] er, ei;
      in_valid  = v;
      in_sof    = sof;
      in_r      = xr;
      in_i      = xi;
      out_ready = ordy;
      #1;
      if (out_valid && out_ready) begin
         s.r = out_r; s.i = out_i; s.idx = int'(out_idx); s.last = out_last; s.cyc = cyc;
         obs_q.push_back(s);
      end
      acc = in_valid && in_ready;
      if (acc) begin
         s.idx = sof ? 0 : m_cnt;
         m_cnt = (s.idx + 1) % 16;
         model(s.idx, xr, xi, er, ei);
         s.r = er; s.i = ei; s.last = (s.idx == 15); s.cyc = cyc;
         exp_q.push_back(s);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int n);
      bit acc;
      repeat (n) step(1'b0, 1'b0, 12'h000, 12'h000, 1'b1, acc);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_r = '0; in_i = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++;
      if ({out_valid, out_last, out_idx} !== 6'd0) $display("FAIL reset_ctrl: valid/last/idx=%b expected 0", {out_valid, out_last, out_idx});
      else n_pass++;
      n_total++;
      if ({out_r, out_i} !== 24'd0) $display("FAIL reset_data: out=%h/%h expected 000/000", out_r, out_i);
      else n_pass++;
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      else n_pass++;
      n_total++;
      if (sel !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", sel);
      else n_pass++;
      m_cnt = 0;
      @(negedge clk);
   endtask

   task automatic test_identity();
      bit acc;
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 16; k++) step(1'b1, k == 0, 12'h123, 12'h0AB, 1'b1, acc);
      drain(6);
      n_total++;
      if (obs_q.size() != 16 || exp_q.size() != 16) $display("FAIL identity_count: got %0d outputs, expected 16", obs_q.size());
      else n_pass++;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_total++;
         if (obs_q[k].r !== exp_q[k].r || obs_q[k].i !== exp_q[k].i || obs_q[k].idx != k || obs_q[k].last !== (k == 15))
            $display("FAIL identity_sample%0d: got %h/%h idx %0d last %b, expected %h/%h idx %0d last %b",
                     k, obs_q[k].r, obs_q[k].i, obs_q[k].idx, obs_q[k].last, exp_q[k].r, exp_q[k].i, k, k == 15);
         else n_pass++;
         if ((k / 4) * (k % 4) == 0) begin
            n_total++;
            if (obs_q[k].r !== 12'h123 || obs_q[k].i !== 12'h0AB)
               $display("FAIL identity_exact%0d: got %h/%h expected 123/0ab", k, obs_q[k].r, obs_q[k].i);
            else n_pass++;
         end
      end
      if (obs_q.size() > 0 && exp_q.size() > 0) begin
         n_total++;
         if (obs_q[0].cyc - exp_q[0].cyc != 3)
            $display("FAIL identity_latency: got %0d cycles expected 3", obs_q[0].cyc - exp_q[0].cyc);
         else n_pass++;
      end
   endtask

   task automatic test_random_rotation();
      bit acc;
      bit started = 1'b0;
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 60; k++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         step(v, v && !started, 12'($urandom), 12'($urandom), $urandom_range(0, 9) < 7, acc);
         if (acc) started = 1'b1;
      end
      drain(8);
      n_total++;
      if (obs_q.size() != exp_q.size()) $display("FAIL random_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_total++;
         if (obs_q[k].r !== exp_q[k].r || obs_q[k].i !== exp_q[k].i || obs_q[k].idx != exp_q[k].idx || obs_q[k].last !== exp_q[k].last)
            $display("FAIL random_sample%0d: got %h/%h idx %0d last %b, expected %h/%h idx %0d last %b",
                     k, obs_q[k].r, obs_q[k].i, obs_q[k].idx, obs_q[k].last, exp_q[k].r, exp_q[k].i, exp_q[k].idx, exp_q[k].last);
         else n_pass++;
      end
   endtask

   task automatic test_negate_saturate();
      bit acc;
      logic [11:0] xr, xi;
      logic [11:0] want_r [5];
      logic [11:0] want_i [5];
      int          pos [5];
      pos = '{5, 10, 15, 26, 30};
      want_r = '{12'h3B2, 12'h080, 12'hC4E, 12'h000, 12'h000};
      want_i = '{12'hE78, 12'hF00, 12'h188, 12'h7FF, 12'h800};
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 32; k++) begin
         xr = 12'($urandom); xi = 12'($urandom);
         case (k)
            5, 15: begin xr = 12'h400; xi = 12'h000; end
            10:    begin xr = 12'h100; xi = 12'h080; end
            26:    begin xr = 12'h800; xi = 12'h000; end
            30:    begin xr = 12'h7FF; xi = 12'h7FF; end
            default: ;
         endcase
         step(1'b1, (k % 16) == 0, xr, xi, 1'b1, acc);
      end
      drain(6);
      n_total++;
      if (obs_q.size() != 32) $display("FAIL negsat_count: got %0d outputs, expected 32", obs_q.size());
      else n_pass++;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_total++;
         if (obs_q[k].r !== exp_q[k].r || obs_q[k].i !== exp_q[k].i || obs_q[k].idx != exp_q[k].idx)
            $display("FAIL negsat_sample%0d: got %h/%h idx %0d, expected %h/%h idx %0d",
                     k, obs_q[k].r, obs_q[k].i, obs_q[k].idx, exp_q[k].r, exp_q[k].i, exp_q[k].idx);
         else n_pass++;
      end
      for (int j = 0; j < 5; j++) begin
         if (pos[j] < obs_q.size()) begin
            n_total++;
            if (obs_q[pos[j]].r !== want_r[j] || obs_q[pos[j]].i !== want_i[j])
               $display("FAIL negsat_point%0d: got %h/%h expected %h/%h", pos[j], obs_q[pos[j]].r, obs_q[pos[j]].i, want_r[j], want_i[j]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      bit pattern [6];
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 6; k++) begin
         step(1'b1, k == 0, 12'($urandom), 12'($urandom), 1'b0, acc);
         pattern[k] = acc;
      end
      for (int k = 0; k < 6; k++) begin
         n_total++;
         if (pattern[k] !== (k < 3)) $display("FAIL bp_accept%0d: got %b expected %b", k, pattern[k], k < 3);
         else n_pass++;
      end
      for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b1, acc);
      drain(6);
      n_total++;
      if (obs_q.size() != exp_q.size() || exp_q.size() != 15)
         $display("FAIL bp_count: got %0d outputs for %0d accepts, expected 15", obs_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_total++;
         if (obs_q[k].r !== exp_q[k].r || obs_q[k].i !== exp_q[k].i || obs_q[k].idx != exp_q[k].idx)
            $display("FAIL bp_sample%0d: got %h/%h idx %0d, expected %h/%h idx %0d",
                     k, obs_q[k].r, obs_q[k].i, obs_q[k].idx, exp_q[k].r, exp_q[k].i, exp_q[k].idx);
         else n_pass++;
      end
   endtask

   task automatic test_resync_reset();
      bit acc;
      exp_q.delete(); obs_q.delete();
      for (int k = 0; k < 7; k++) step(1'b1, k == 0, 12'($urandom), 12'($urandom), 1'b1, acc);
      in_valid = 1'b1; in_sof = 1'b0; out_ready = 1'b1;
      #1;
      n_total++;
      if (sel !== 3'd3) $display("FAIL resync_sel_cnt7: got %0d expected 3", sel);
      else n_pass++;
      in_sof = 1'b1;
      #1;
      n_total++;
      if (sel !== 3'd0) $display("FAIL resync_sel_sof: got %0d expected 0", sel);
      else n_pass++;
      step(1'b1, 1'b1, 12'h400, 12'h000, 1'b1, acc);
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 12'($urandom), 12'($urandom), 1'b1, acc);
      drain(6);
      n_total++;
      if (obs_q.size() != 13 || obs_q[7].idx != 0 || obs_q[8].idx != 1)
         $display("FAIL resync_idx: got %0d outputs, idx after resync %0d, expected 13 outputs and idx 0",
                  obs_q.size(), (obs_q.size() > 7) ? obs_q[7].idx : -1);
      else n_pass++;
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         n_total++;
         if (obs_q[k].r !== exp_q[k].r || obs_q[k].i !== exp_q[k].i || obs_q[k].idx != exp_q[k].idx)
            $display("FAIL resync_sample%0d: got %h/%h idx %0d, expected %h/%h idx %0d",
                     k, obs_q[k].r, obs_q[k].i, obs_q[k].idx, exp_q[k].r, exp_q[k].i, exp_q[k].idx);
         else n_pass++;
      end

      for (int k = 0; k < 5; k++) step(1'b1, k == 0, 12'($urandom), 12'($urandom), 1'b0, acc);
      n_total++;
      if (out_valid !== 1'b1) $display("FAIL rst_prefill: out_valid %b expected 1", out_valid);
      else n_pass++;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_midframe_valid: got %b expected 0", out_valid);
      else n_pass++;
      rst = 1'b0;
      exp_q.delete(); obs_q.delete();
      m_cnt = 0;
      step(1'b1, 1'b0, 12'h100, 12'h080, 1'b1, acc);
      drain(6);
      n_total++;
      if (obs_q.size() != 1 || obs_q[0].idx != 0 || obs_q[0].r !== 12'h100 || obs_q[0].i !== 12'h080)
         $display("FAIL rst_first_idx: got %0d outputs, first idx %0d data %h/%h, expected 1 output idx 0 data 100/080",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0].idx : -1,
                  (obs_q.size() > 0) ? obs_q[0].r : 12'h000, (obs_q.size() > 0) ? obs_q[0].i : 12'h000);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_random_rotation();
      test_negate_saturate();
      test_backpressure();
      test_resync_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
